// File: rtl/rename_ckpt_if.sv
// Handshake bundle between the dispatch/free-list side and the branch
// checkpoint controller.
interface rename_ckpt_if #(
    parameter int NCKPT = 4,
    parameter int PTR_W = 7
);
    localparam int TAG_W = $clog2(NCKPT);

    logic               br_alloc_req;
    logic               br_alloc_gnt;
    logic [TAG_W-1:0]   br_tag;
    logic [PTR_W-1:0]   fl_r_ptr;
    logic               br_resolve_valid;
    logic [TAG_W-1:0]   br_resolve_tag;
    logic               br_mispredict;
    logic               restore_valid;
    logic [PTR_W-1:0]   restore_r_ptr;
    logic               dispatch_stall;
    logic [TAG_W:0]     ckpt_count;

    // Requester / free-list side
    modport master (
        output br_alloc_req, fl_r_ptr, br_resolve_valid, br_resolve_tag, br_mispredict,
        input  br_alloc_gnt, br_tag, restore_valid, restore_r_ptr, dispatch_stall, ckpt_count
    );

    // Checkpoint controller side
    modport slave (
        input  br_alloc_req, fl_r_ptr, br_resolve_valid, br_resolve_tag, br_mispredict,
        output br_alloc_gnt, br_tag, restore_valid, restore_r_ptr, dispatch_stall, ckpt_count
    );
endinterface

// File: rtl/rename_ckpt_ctrl.sv
// Branch checkpoint controller: allocates a checkpoint slot per dispatched
// branch holding the free-list read pointer, frees slots on correct resolve,
// and on a mispredict issues a one-cycle pointer restore while squashing all
// younger checkpoints and stalling dispatch for the recovery cycle.
module rename_ckpt_ctrl #(
    parameter int NCKPT    = 4,
    parameter int PTR_W    = 7,
    parameter int FL_DEPTH = 96
) (
    input  logic            clk,
    input  logic            reset,
    rename_ckpt_if.slave    ckpt
);
    localparam int TAG_W = $clog2(NCKPT);
    localparam int CNT_W = TAG_W + 1;

    if ((1 << TAG_W) != NCKPT || NCKPT < 2 || NCKPT > 16) begin : g_bad_nckpt
        $error("rename_ckpt_ctrl: NCKPT must be a power of two in 2..16");
    end
    if (FL_DEPTH < 1 || FL_DEPTH > (1 << PTR_W)) begin : g_bad_depth
        $error("rename_ckpt_ctrl: FL_DEPTH must fit in PTR_W bits");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NCKPT-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   saved_ptr_q [NCKPT];
    logic [PTR_W-1:0]   saved_ptr_d [NCKPT];
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic               restore_valid_q, restore_valid_d;
    logic [PTR_W-1:0]   restore_r_ptr_q, restore_r_ptr_d;
    logic [CNT_W-1:0]   ckpt_count_q, ckpt_count_d;

    logic               gnt;
    logic               mispredict_hit;
    logic               resolve_hit;
    logic [TAG_W-1:0]   squash_span;

    // Grant and stall decode from current state and inputs
    always_comb begin
        gnt = ckpt.br_alloc_req && !valid_q[tail_q] && (state_q == IDLE)
              && !(ckpt.br_resolve_valid && ckpt.br_mispredict);
        mispredict_hit = (state_q == IDLE) && ckpt.br_resolve_valid && ckpt.br_mispredict
                         && valid_q[ckpt.br_resolve_tag];
        resolve_hit    = (state_q == IDLE) && ckpt.br_resolve_valid && !ckpt.br_mispredict
                         && valid_q[ckpt.br_resolve_tag];
        squash_span    = tail_q - ckpt.br_resolve_tag;
    end

    assign ckpt.br_alloc_gnt   = gnt;
    assign ckpt.br_tag         = tail_q;
    assign ckpt.restore_valid  = restore_valid_q;
    assign ckpt.restore_r_ptr  = restore_r_ptr_q;
    assign ckpt.ckpt_count     = ckpt_count_q;
    assign ckpt.dispatch_stall = (state_q == RECOVER) || (ckpt.br_alloc_req && !gnt);

    // Next-state: slot table, tail, recovery FSM, restore pulse and occupancy
    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        saved_ptr_d     = saved_ptr_q;
        tail_d          = tail_q;
        restore_valid_d = 1'b0;
        restore_r_ptr_d = restore_r_ptr_q;
        ckpt_count_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (mispredict_hit) begin
                    // Squash the circular range [tag, tail). A zero span with
                    // the tag valid means the ring is full, so every slot goes.
                    for (int unsigned i = 0; i < NCKPT; i++) begin
                        if (squash_span == '0 ||
                            TAG_W'(TAG_W'(i) - ckpt.br_resolve_tag) < squash_span) begin
                            valid_d[i] = 1'b0;
                        end
                    end
                    restore_valid_d = 1'b1;
                    restore_r_ptr_d = saved_ptr_q[ckpt.br_resolve_tag];
                    tail_d          = ckpt.br_resolve_tag;
                    state_d         = RECOVER;
                end else begin
                    if (resolve_hit) begin
                        valid_d[ckpt.br_resolve_tag] = 1'b0;
                    end
                    if (gnt) begin
                        valid_d[tail_q]     = 1'b1;
                        saved_ptr_d[tail_q] = ckpt.fl_r_ptr;
                        tail_d              = tail_q + TAG_W'(1);
                    end
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned i = 0; i < NCKPT; i++) begin
            ckpt_count_d = ckpt_count_d + CNT_W'(valid_d[i]);
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            tail_q          <= '0;
            restore_valid_q <= 1'b0;
            restore_r_ptr_q <= '0;
            ckpt_count_q    <= '0;
            for (int unsigned i = 0; i < NCKPT; i++) begin
                saved_ptr_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            tail_q          <= tail_d;
            restore_valid_q <= restore_valid_d;
            restore_r_ptr_q <= restore_r_ptr_d;
            ckpt_count_q    <= ckpt_count_d;
            saved_ptr_q     <= saved_ptr_d;
        end
    end
endmodule

// File: doc/rename_ckpt_ctrl.md
Name: rename_ckpt_ctrl

Overview:
- Branch checkpoint controller for the rename stage's physical-register free list.
- Grants a checkpoint slot to each dispatched branch and records the free-list read pointer at that point.
- Frees slots as branches resolve correctly.
- On a mispredict, drives a one-cycle pointer-restore command to the free list, squashes all younger checkpoints, and stalls dispatch for the recovery cycle.

Parameters:
- NCKPT, 4, number of checkpoint slots; power of two, 2..16.
- PTR_W, 7, free-list pointer width.
- FL_DEPTH, 96, free-list entry count; bounds legal pointer values 0..FL_DEPTH-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- br_alloc_req  input  1  dispatching branch needs a checkpoint this cycle.
- br_alloc_gnt  output  1  checkpoint granted this cycle (combinational).
- br_tag  output  $clog2(NCKPT)  slot index of the grant; equals the tail pointer.
- fl_r_ptr  input  PTR_W  free-list read pointer, sampled on grant.
- br_resolve_valid  input  1  a branch resolves this cycle.
- br_resolve_tag  input  $clog2(NCKPT)  tag of the resolving branch.
- br_mispredict  input  1  qualifies br_resolve_valid; 1 = mispredicted.
- restore_valid  output  1  registered one-cycle restore pulse to the free list.
- restore_r_ptr  output  PTR_W  saved read pointer to restore.
- dispatch_stall  output  1  blocks rename and dispatch.
- ckpt_count  output  $clog2(NCKPT)+1  number of valid slots.

Behaviour:
Storage and reset:
- Per slot: valid bit and saved_ptr[PTR_W].
- tail register: $clog2(NCKPT) bits, wraps NCKPT-1 -> 0.
- State register: IDLE or RECOVER.
- Reset: all valid=0, tail=0, state=IDLE, restore_valid=0, restore_r_ptr=0, dispatch_stall=0, ckpt_count=0. Reset wins over every other input, including mid-RECOVER.

Allocation:
- br_alloc_gnt = br_alloc_req && !valid[tail] && state==IDLE && !(br_resolve_valid && br_mispredict).
- On grant: next edge sets valid[tail]=1, saved_ptr[tail]=fl_r_ptr, tail=tail+1 mod NCKPT.
- Full condition is valid[tail]=1. A valid slot at tail blocks allocation even if other slots are free; no search for free slots.
- A request is never queued; the requester holds br_alloc_req until granted.

Correct resolve (br_resolve_valid=1, br_mispredict=0):
- Next edge clears valid[br_resolve_tag]. tail is unchanged.
- Resolve on an invalid tag is ignored, with no state change.
- Legal in the same cycle as a grant, because the granted tag is invalid and so cannot match.

Mispredict (br_resolve_valid=1, br_mispredict=1, valid[tag]=1, state==IDLE):
- Next edge, cycle T+1:
  - restore_valid=1 and restore_r_ptr=saved_ptr[tag].
  - Every slot in the circular range [tag, old tail) is cleared.
  - tail=tag.
  - state=RECOVER.
- In RECOVER: dispatch_stall=1, grants blocked, resolve inputs ignored.
- Next edge: state=IDLE and restore_valid=0. restore_valid is high for exactly one cycle.
- Mispredict on an invalid tag is ignored; state stays IDLE and no restore is issued.
- If the mispredict tag equals old tail-1, only that slot is cleared.

dispatch_stall:
- dispatch_stall = (state==RECOVER) || (br_alloc_req && !br_alloc_gnt).

ckpt_count:
- Registered popcount of the valid bits, updated the same edge as the valid bits.
- Range 0..NCKPT.

Width rules:
- restore_r_ptr is driven only from saved values; no arithmetic on pointers in this block.
- The free list computes the occupancy delta from its own pointers.

Test Plan:
- After reset, 4 alloc requests with fl_r_ptr = 5, 9, 12, 20 -> grants in consecutive cycles with tags 0, 1, 2, 3; ckpt_count=4. 5th request -> br_alloc_gnt=0 and dispatch_stall=1.
- With 4 valid slots, correct resolve of tag 0, then request -> grant tag 0 next cycle; saved_ptr = new fl_r_ptr; tail=1.
- Slots 0..3 valid (ptrs 5, 9, 12, 20), mispredict tag 1 -> next cycle restore_valid=1, restore_r_ptr=9, slots 1..3 cleared, ckpt_count=1, dispatch_stall=1 for one cycle. Following request -> tag 1.
- Wrap case: tail=1, slots 2, 3, 0 valid, mispredict tag 3 -> slots 3 and 0 cleared, slot 2 kept, tail=3.
- Simultaneous alloc request and mispredict in the same cycle -> br_alloc_gnt=0, no new slot written. Resolve with an invalid tag -> no change.
- Reset asserted during the RECOVER cycle -> next cycle all outputs at reset values; ckpt_count=0; tail=0.
